deck_dealer: RTL and testbench
==============================

Name: deck_dealer

Overview:
- Sequences the shuffled 108-card deck for the game.
- Starts a shuffle, deals the opening hands round-robin, then arbitrates draw requests (normal draw, draw two, wild draw four) between players.
- Hands out cards one per cycle in deck order.
- Triggers a reshuffle when the draw pointer runs off the end of the deck.
- Sits between the deck shuffler and the per-player hand/game-logic blocks.

Parameters:
- NUM_PLAYERS, 4, number of requesters; supported range 2..4.
- DECK_SIZE, 108, number of cards in the deck.
- HAND_INIT, 7, cards dealt to each player at game start.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_start_deal  in  1  pulse; begins a new game (shuffle, then deal).
- o_shuffle_start  out  1  one-cycle pulse to the shuffler.
- i_shuffle_done  in  1  pulse from the shuffler; deck contents are now valid.
- o_deck_addr  out  7  deck index currently being read; equals the draw pointer.
- i_deck_card  in  6  card at o_deck_addr, combinational read: {color[1:0], value[3:0]}.
- i_req  in  NUM_PLAYERS  per-player draw request level; held until granted.
- i_req_cnt  in  3*NUM_PLAYERS  per-player card count; player p uses bits [3p+2:3p].
- o_grant  out  NUM_PLAYERS  one-hot, one-cycle grant pulse.
- o_card_valid  out  1  o_card and o_card_player are valid this cycle.
- o_card  out  6  dealt card.
- o_card_player  out  2  destination player index.
- o_deal_done  out  1  one-cycle pulse after the last opening card.
- o_busy  out  1  high in every state except IDLE and READY.
- o_remaining  out  7  DECK_SIZE − draw pointer.
- o_empty  out  1  high while waiting on a reshuffle caused by exhaustion.

Behaviour:
- Reset: i_rst_n is asynchronous and active-low; clock is i_clk.
- Reset values: state IDLE, ptr=0, rr_ptr=0, all pulses 0, o_card=0, o_card_player=0, o_empty=0, o_remaining=DECK_SIZE.
- Reset mid-operation aborts everything. Any card in flight is dropped; no o_card_valid is issued after reset.
- States: IDLE, SHUF_WAIT, DEAL, READY, SERVE.
- IDLE:
  - i_start_deal → o_shuffle_start=1 for one cycle, go to SHUF_WAIT.
  - i_req is ignored.
- SHUF_WAIT:
  - On i_shuffle_done: ptr←0, o_empty←0.
  - Next state is DEAL if dealing was pending, otherwise SERVE (resuming an exhausted draw).
- DEAL:
  - Each cycle: o_card←i_deck_card, o_card_player←deal_idx mod NUM_PLAYERS, o_card_valid←1 (registered, appears next cycle), ptr++.
  - Players receive cards cyclically 0,1,..,N-1,0,…
  - After NUM_PLAYERS*HAND_INIT cards (28 by default): o_deal_done pulses in the same cycle as the final o_card_valid, then go to READY.
- READY:
  - Round-robin arbitration among asserted i_req, searching from rr_ptr upward with wrap.
  - Winner w: o_grant[w]=1 for one cycle.
  - Latch cnt = i_req_cnt[w], with 0→1 and values >4 clamped to 4.
  - rr_ptr←(w+1) mod NUM_PLAYERS; go to SERVE.
  - The requester must drop i_req the cycle after its grant. A still-high request is treated as a new request.
- SERVE:
  - Issues cnt cards to w, one per cycle, with the same timing as DEAL.
  - Returns to READY after the last card. The next grant can occur in the cycle after the last o_card_valid.
- Exhaustion:
  - Applies in DEAL or SERVE when a card is needed and ptr==DECK_SIZE.
  - No card is issued; o_empty←1; o_shuffle_start pulses; go to SHUF_WAIT.
  - The outstanding deal index or cnt and the granted player are preserved.
- ptr arithmetic:
  - ptr is 7 bits and never exceeds DECK_SIZE.
  - o_remaining is combinational from ptr.
- Ignored inputs:
  - i_start_deal outside IDLE.
  - i_shuffle_done outside SHUF_WAIT.
- Simultaneous requests are resolved by rr_ptr only. No requester is starved: at most NUM_PLAYERS-1 grants go to others before it is granted.

Test Plan:
- Opening deal: reset, i_start_deal, then i_shuffle_done 5 cycles later → o_shuffle_start pulses once. 28 consecutive o_card_valid with players 0,1,2,3 repeating, cards = deck[0..27]. o_deal_done coincides with the 28th card; o_remaining=80.
- Single draw: after the deal, i_req=0001 with cnt=2 → o_grant=0001, then 2 cards (deck[28], deck[29]) to player 0; o_remaining=78.
- Round-robin: i_req=1111 held, each requester dropping its request after its grant, rr_ptr=0 → grants in order 0,1,2,3, each followed by its count of cards. A second batch starting with rr_ptr=2 → grants 2,3,0,1.
- Clamping: i_req_cnt=0 → 1 card; i_req_cnt=7 → 4 cards.
- Exhaustion: force ptr=106, request cnt=4 → 2 cards issued, then o_empty=1 and o_shuffle_start pulses. After i_shuffle_done: 2 more cards from deck[0..1], all to the same player; o_remaining=106.
- Reset mid-deal: assert i_rst_n low after the 10th card → outputs return to reset values immediately; no o_card_valid until a new i_start_deal.

Source files
------------

// File: rtl/deck_dealer.sv
// Deck sequencer: kicks the shuffler, deals opening hands round-robin, then
// serves draw requests one card per cycle, reshuffling when the deck runs out.
`timescale 1ns/1ps
module deck_dealer #(
  parameter int NUM_PLAYERS = 4,
  parameter int DECK_SIZE   = 108,
  parameter int HAND_INIT   = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start_deal,
  output logic                     o_shuffle_start,
  input  logic                     i_shuffle_done,
  output logic [6:0]               o_deck_addr,
  input  logic [5:0]               i_deck_card,
  input  logic [NUM_PLAYERS-1:0]   i_req,
  input  logic [3*NUM_PLAYERS-1:0] i_req_cnt,
  output logic [NUM_PLAYERS-1:0]   o_grant,
  output logic                     o_card_valid,
  output logic [5:0]               o_card,
  output logic [1:0]               o_card_player,
  output logic                     o_deal_done,
  output logic                     o_busy,
  output logic [6:0]               o_remaining,
  output logic                     o_empty
);
  localparam logic [6:0] DECK_END  = 7'(DECK_SIZE);
  localparam logic [6:0] DEAL_LAST = 7'(NUM_PLAYERS * HAND_INIT - 1);
  localparam logic [1:0] LAST_P    = 2'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {IDLE, SHUF_WAIT, DEAL, READY, SERVE} state_t;

  state_t                 state_q, state_d;
  logic [6:0]             ptr_q, ptr_d, deal_idx_q, deal_idx_d;
  logic [1:0]             deal_p_q, deal_p_d, rr_q, rr_d, player_q, player_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   shuf_q, shuf_d, valid_q, valid_d, done_q, done_d;
  logic                   empty_q, empty_d;
  logic [NUM_PLAYERS-1:0] grant_q, grant_d;
  logic [5:0]             card_q, card_d;
  logic [1:0]             cplayer_q, cplayer_d;

  // Arbitration: first asserted request at or after rr_q, with wrap.
  logic [3:0]  req_pad;
  logic [11:0] cnt_pad;
  logic        found;
  logic [1:0]  win, cand;
  logic [2:0]  raw_cnt, clamp_cnt;

  always_comb begin
    req_pad = 4'(i_req);
    cnt_pad = 12'(i_req_cnt);
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    raw_cnt = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      cand = 2'((int'(rr_q) + i) % NUM_PLAYERS);
      if (req_pad[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (win == 2'(p)) raw_cnt = cnt_pad[3*p +: 3];
    end
    if (raw_cnt == 3'd0)      clamp_cnt = 3'd1;
    else if (raw_cnt > 3'd4)  clamp_cnt = 3'd4;
    else                      clamp_cnt = raw_cnt;
  end

  // Request/grant: i_req is a level held until o_grant pulses for that player;
  // the player must drop it the cycle after the grant or it counts as a new request.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    deal_idx_d = deal_idx_q;
    deal_p_d  = deal_p_q;
    rr_d      = rr_q;
    player_d  = player_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    shuf_d    = 1'b0;
    grant_d   = '0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    card_d    = card_q;
    cplayer_d = cplayer_q;
    empty_d   = empty_q;
    case (state_q)
      IDLE: begin
        if (i_start_deal) begin
          shuf_d     = 1'b1;
          pend_d     = 1'b1;
          deal_idx_d = '0;
          deal_p_d   = '0;
          state_d    = SHUF_WAIT;
        end
      end
      SHUF_WAIT: begin
        if (i_shuffle_done) begin
          ptr_d   = '0;
          empty_d = 1'b0;
          state_d = pend_q ? DEAL : SERVE;
        end
      end
      DEAL: begin
        if (ptr_q == DECK_END) begin
          empty_d = 1'b1;
          shuf_d  = 1'b1;
          state_d = SHUF_WAIT;
        end else begin
          valid_d    = 1'b1;
          card_d     = i_deck_card;
          cplayer_d  = deal_p_q;
          ptr_d      = ptr_q + 7'd1;
          deal_idx_d = deal_idx_q + 7'd1;
          deal_p_d   = (deal_p_q == LAST_P) ? 2'd0 : deal_p_q + 2'd1;
          if (deal_idx_q == DEAL_LAST) begin
            done_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = READY;
          end
        end
      end
      READY: begin
        if (found) begin
          grant_d  = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << win;
          cnt_d    = clamp_cnt;
          player_d = win;
          rr_d     = (win == LAST_P) ? 2'd0 : win + 2'd1;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (ptr_q == DECK_END) begin
          empty_d = 1'b1;
          shuf_d  = 1'b1;
          state_d = SHUF_WAIT;
        end else begin
          valid_d   = 1'b1;
          card_d    = i_deck_card;
          cplayer_d = player_q;
          ptr_d     = ptr_q + 7'd1;
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      deal_idx_q <= '0;
      deal_p_q   <= '0;
      rr_q       <= '0;
      player_q   <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      shuf_q     <= 1'b0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      card_q     <= '0;
      cplayer_q  <= '0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      deal_idx_q <= deal_idx_d;
      deal_p_q   <= deal_p_d;
      rr_q       <= rr_d;
      player_q   <= player_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      shuf_q     <= shuf_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      card_q     <= card_d;
      cplayer_q  <= cplayer_d;
      empty_q    <= empty_d;
    end
  end

  assign o_shuffle_start = shuf_q;
  assign o_deck_addr     = ptr_q;
  assign o_grant         = grant_q;
  assign o_card_valid    = valid_q;
  assign o_card          = card_q;
  assign o_card_player   = cplayer_q;
  assign o_deal_done     = done_q;
  assign o_empty         = empty_q;
  assign o_busy          = !(state_q == IDLE || state_q == READY);
  assign o_remaining     = DECK_END - ptr_q;
endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: card-level reference model feeding expected queues,
// with a monitor that pops and compares whenever the dealer presents output.
`timescale 1ns/1ps
module tb_deck_dealer;
  localparam int N    = 4;
  localparam int DECK = 108;
  localparam int HAND = 7;

  logic           clk, rst_n, start_deal, shuffle_start, shuffle_done;
  logic [6:0]     deck_addr, remaining;
  logic [5:0]     deck_card, card;
  logic [N-1:0]   req, grant;
  logic [3*N-1:0] req_cnt;
  logic           card_valid, deal_done, busy, empty;
  logic [1:0]     card_player;

  deck_dealer #(.NUM_PLAYERS(N), .DECK_SIZE(DECK), .HAND_INIT(HAND)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_deal(start_deal),
    .o_shuffle_start(shuffle_start), .i_shuffle_done(shuffle_done),
    .o_deck_addr(deck_addr), .i_deck_card(deck_card),
    .i_req(req), .i_req_cnt(req_cnt), .o_grant(grant),
    .o_card_valid(card_valid), .o_card(card), .o_card_player(card_player),
    .o_deal_done(deal_done), .o_busy(busy), .o_remaining(remaining),
    .o_empty(empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two deck banks: the shuffler flips rbank on each done pulse, the model flips mbank.
  logic [5:0] bank [0:1][0:DECK-1];
  logic       rbank, mbank;

  always_comb begin
    deck_card = '0;
    if (deck_addr < 7'(DECK)) deck_card = bank[rbank][deck_addr];
  end

  int         checks, errors, cards_seen;
  int         mptr, mrr;
  logic [8:0]   exp_q[$];
  logic [N-1:0] gnt_q[$];
  logic         shuf_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: one card leaves the deck in order, reshuffle on exhaustion
  function automatic void take(input int p, input bit done);
    if (mptr == DECK) begin
      shuf_q.push_back(1'b1);
      mbank = ~mbank;
      mptr  = 0;
    end
    exp_q.push_back({done, 2'(p), bank[mbank][mptr]});
    mptr++;
  endfunction

  // shuffler stand-in
  initial begin : shuffler
    shuffle_done = 1'b0;
    rbank = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DECK; i++) bank[b][i] = 6'($urandom);
    forever begin
      @(negedge clk);
      if (rst_n && shuffle_start) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rbank = ~rbank;
        shuffle_done = 1'b1;
        @(negedge clk);
        shuffle_done = 1'b0;
        for (int i = 0; i < DECK; i++) bank[~rbank][i] = 6'($urandom);
      end
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    logic [8:0]   e;
    logic [N-1:0] g;
    logic         s;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (card_valid) begin
          cards_seen++;
          if (exp_q.size() == 0) chk("card_unexpected", 32'(card_valid), 0);
          else begin
            e = exp_q.pop_front();
            chk("card", {23'd0, deal_done, card_player, card}, {23'd0, e});
          end
        end else if (deal_done) chk("deal_done_stray", 32'(deal_done), 0);
        if (grant != '0) begin
          if (gnt_q.size() == 0) chk("grant_unexpected", 32'(grant), 0);
          else begin
            g = gnt_q.pop_front();
            chk("grant", 32'(grant), 32'(g));
          end
        end
        if (shuffle_start) begin
          if (shuf_q.size() == 0) chk("shuffle_unexpected", 32'(shuffle_start), 0);
          else begin
            s = shuf_q.pop_front();
            chk("shuffle_empty_flag", 32'(empty), 32'(s));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check_reset_vals(input string tag);
    chk({tag, "_remaining"}, 32'(remaining), 32'(DECK));
    chk({tag, "_valid"}, 32'(card_valid), 0);
    chk({tag, "_card"}, 32'({card_player, card}), 0);
    chk({tag, "_pulses"}, 32'({grant, deal_done, shuffle_start}), 0);
    chk({tag, "_busy_empty"}, 32'({busy, empty}), 0);
    chk({tag, "_addr"}, 32'(deck_addr), 0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    gnt_q.delete();
    shuf_q.delete();
    req = '0;
    req_cnt = '0;
    start_deal = 1'b0;
    mrr = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      req = req & ~grant;
      n++;
    end while ((exp_q.size() != 0 || gnt_q.size() != 0 || shuf_q.size() != 0 ||
                busy || req != '0) && n < 3000);
    chk({"drain_", tag}, 32'(n < 3000), 1);
    repeat (2) @(negedge clk);
    chk({tag, "_remaining"}, 32'(remaining), 32'(DECK - mptr));
  endtask

  task automatic push_game();
    shuf_q.push_back(1'b0);
    mbank = ~mbank;
    mptr = 0;
    for (int k = 0; k < N * HAND; k++) take(k % N, k == N * HAND - 1);
    start_deal = 1'b1;
    @(negedge clk);
    start_deal = 1'b0;
  endtask

  task automatic batch(input logic [N-1:0] mask, input logic [3*N-1:0] cnts, input string tag);
    int p, n, last;
    logic [2:0] raw;
    logic [N-1:0] one;
    one = 1;
    last = -1;
    for (int i = 0; i < N; i++) begin
      p = (mrr + i) % N;
      if (mask[p]) begin
        gnt_q.push_back(one << p);
        raw = cnts[3*p +: 3];
        n = (raw == 0) ? 1 : (raw > 4) ? 4 : int'(raw);
        for (int j = 0; j < n; j++) take(p, 1'b0);
        last = p;
      end
    end
    if (last >= 0) mrr = (last + 1) % N;
    req_cnt = cnts;
    req = mask;
    drain(tag);
  endtask

  task automatic single(input int p, input int n, input string tag);
    logic [3*N-1:0] c;
    logic [N-1:0]   m;
    c = '0;
    c[3*p +: 3] = 3'(n);
    m = '0;
    m[p] = 1'b1;
    batch(m, c, tag);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int base, n;
    logic [N-1:0]   m;
    logic [3*N-1:0] c;
    checks = 0; errors = 0; cards_seen = 0;
    mptr = 0; mbank = 1'b0;
    rst_n = 1'b0;
    flush_model();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    push_game();
    drain("deal");
    single(0, 2, "single");
    single(3, 0, "clamp_zero");
    batch(4'b1111, 12'b010_001_111_011, "rr_batch1");
    single(1, 1, "rr_setup");
    batch(4'b1111, 12'b100_011_010_001, "rr_batch2");

    for (int b = 0; b < 40; b++) begin
      m = 4'($urandom_range(1, 15));
      c = 12'($urandom);
      batch(m, c, "rand");
    end

    while (mptr != 106) begin
      n = (mptr > 106) ? 4 : ((106 - mptr > 4) ? 4 : 106 - mptr);
      single($urandom_range(0, N - 1), n, "approach");
    end
    single(2, 4, "exhaust");

    rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = cards_seen;
    push_game();
    n = 0;
    while (cards_seen < base + 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("mid_deal_reach10", 32'(cards_seen - base), 10);
    rst_n = 1'b0;
    #1;
    flush_model();
    check_reset_vals("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_quiet", 32'(cards_seen - base), 10);

    push_game();
    drain("redeal");
    batch(4'b0110, 12'($urandom), "after_redeal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
